// File: rtl/peripheral_msi_arbiter_ahb3_if.sv
// ---------------------------------------------------------------------------
// peripheral_msi_arbiter_ahb3_if
// Bundle of the signals between the requesting masters and the slave-port
// arbiter of one AHB3-Lite slave port.
//   mst_req            per-master request (HSEL qualified by HTRANS[1])
//   mst_priority       per-master 3-bit priority, 7 is highest
//   mst_HTRANS         per-master HTRANS
//   mst_HBURST         per-master HBURST
//   mst_HMASTLOCK      per-master lock
//   slv_HREADY         slave-port HREADY
//   granted_master     one-hot grant (registered)
//   granted_master_idx binary grant index (registered)
//   grant_valid        granted master is requesting or mid-transfer
//   can_switch         arbitration point this cycle (combinational)
//   starved            per-master starved flag (registered)
// Modport "master" is the side that drives requests; "slave" is the arbiter.
// ---------------------------------------------------------------------------
interface peripheral_msi_arbiter_ahb3_if #(
   parameter int MASTERS = 5
);
   localparam int IDXW = $clog2(MASTERS);

   logic [MASTERS-1:0]       mst_req;
   logic [MASTERS-1:0][2:0]  mst_priority;
   logic [MASTERS-1:0][1:0]  mst_HTRANS;
   logic [MASTERS-1:0][2:0]  mst_HBURST;
   logic [MASTERS-1:0]       mst_HMASTLOCK;
   logic                     slv_HREADY;
   logic [MASTERS-1:0]       granted_master;
   logic [IDXW-1:0]          granted_master_idx;
   logic                     grant_valid;
   logic                     can_switch;
   logic [MASTERS-1:0]       starved;

   modport master (
      output mst_req, mst_priority, mst_HTRANS, mst_HBURST, mst_HMASTLOCK, slv_HREADY,
      input  granted_master, granted_master_idx, grant_valid, can_switch, starved
   );

   modport slave (
      input  mst_req, mst_priority, mst_HTRANS, mst_HBURST, mst_HMASTLOCK, slv_HREADY,
      output granted_master, granted_master_idx, grant_valid, can_switch, starved
   );
endinterface

// File: rtl/peripheral_msi_arbiter_ahb3.sv
// ---------------------------------------------------------------------------
// peripheral_msi_arbiter_ahb3
// Registered, burst- and lock-aware arbiter for one AHB3-Lite slave port.
// Priority tiers with per-tier round-robin; requesters that wait AGE_LIMIT
// cycles are promoted to a "starved" tier above priority 7.
// Ports:
//   HCLK    clock, rising edge
//   HRESET  asynchronous active-high reset
//   bus     peripheral_msi_arbiter_ahb3_if.slave (requests in, grant out)
// ---------------------------------------------------------------------------
module peripheral_msi_arbiter_ahb3 #(
   parameter int MASTERS   = 5,
   parameter int AGE_LIMIT = 15
) (
   input logic                            HCLK,
   input logic                            HRESET,
   peripheral_msi_arbiter_ahb3_if.slave   bus
);
   localparam int IDXW         = $clog2(MASTERS);
   localparam int TIERS        = 9;
   localparam int STARVED_TIER = 8;
   localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_BURST, ST_LOCKED} state_t;

   state_t             state_q, state_d;
   logic [3:0]         beats_q, beats_d;
   logic               lock_pend_q, lock_pend_d;
   logic [MASTERS-1:0] grant_q, grant_d;
   logic [IDXW-1:0]    idx_q, idx_d;
   logic               gv_q, gv_d;
   logic [IDXW-1:0]    ptr_q [TIERS];
   logic [IDXW-1:0]    ptr_d [TIERS];

   logic [MASTERS-1:0]            starved_vec;
   logic [TIERS-1:0][MASTERS-1:0] tier_req;
   logic [3:0]                    win_tier;
   logic [IDXW-1:0]               winner;
   logic                          any_req;
   logic                          rr_found;
   int                            cand;
   logic [IDXW-1:0]               cand_idx;
   logic                          arb_point;
   logic                          burst_done;
   logic                          can_switch;
   logic                          grant_load;
   logic [3:0]                    burst_len;

   // Signals of the currently granted master.
   logic [1:0] cur_htrans;
   logic [2:0] cur_hburst;
   logic       cur_lock;

   assign cur_htrans = bus.mst_HTRANS[idx_q];
   assign cur_hburst = bus.mst_HBURST[idx_q];
   assign cur_lock   = bus.mst_HMASTLOCK[idx_q];

   // A starved requester sits only in the top tier, never in its priority tier.
   for (genvar gi = 0; gi < TIERS; gi++) begin : g_tier
      for (genvar gj = 0; gj < MASTERS; gj++) begin : g_mst
         if (gi == STARVED_TIER) begin : g_top
            assign tier_req[gi][gj] = bus.mst_req[gj] & starved_vec[gj];
         end else begin : g_prio
            assign tier_req[gi][gj] = bus.mst_req[gj] & ~starved_vec[gj] &
                                      (bus.mst_priority[gj] == 3'(gi));
         end
      end
   end

   // Highest non-empty tier, then round-robin starting after its pointer.
   always_comb begin
      win_tier = '0;
      any_req  = 1'b0;
      winner   = idx_q;
      rr_found = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int t = 0; t < TIERS; t++) begin
         if (|tier_req[t]) begin
            win_tier = 4'(t);
            any_req  = 1'b1;
         end
      end
      for (int k = 1; k <= MASTERS; k++) begin
         cand = int'(ptr_q[win_tier]) + k;
         if (cand >= MASTERS) cand = cand - MASTERS;
         cand_idx = IDXW'(cand);
         if (!rr_found && tier_req[win_tier][cand_idx]) begin
            winner   = cand_idx;
            rr_found = 1'b1;
         end
      end
   end

   // Remaining SEQ beats after the NONSEQ: 4-, 8- or 16-beat bursts.
   always_comb begin
      case (cur_hburst[2:1])
         2'b01:   burst_len = 4'd3;
         2'b10:   burst_len = 4'd7;
         default: burst_len = 4'd15;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      beats_d     = beats_q;
      lock_pend_d = lock_pend_q;
      grant_d     = grant_q;
      idx_d       = idx_q;
      gv_d        = gv_q;
      ptr_d       = ptr_q;
      arb_point   = 1'b0;
      burst_done  = 1'b0;
      can_switch  = 1'b0;
      grant_load  = 1'b0;

      if (bus.slv_HREADY) begin
         case (state_q)
            ST_OWNED: begin
               if (cur_lock) begin
                  state_d = ST_LOCKED;
               end else if (cur_htrans == HT_NONSEQ && cur_hburst >= 3'd2) begin
                  state_d     = ST_BURST;
                  beats_d     = burst_len;
                  lock_pend_d = 1'b0;
               end else if (cur_htrans == HT_IDLE) begin
                  arb_point = 1'b1;
               end
            end
            ST_BURST: begin
               // Lock seen mid-burst is remembered and honoured at burst end.
               if (cur_lock) lock_pend_d = 1'b1;
               if (cur_htrans == HT_SEQ) begin
                  if (beats_q == 4'd0) burst_done = 1'b1;
                  else                 beats_d    = beats_q - 4'd1;
               end else if (cur_htrans == HT_IDLE) begin
                  // Master abandoned the burst early; do not hang the port.
                  burst_done = 1'b1;
               end
               if (burst_done) begin
                  lock_pend_d = 1'b0;
                  if (cur_lock || lock_pend_q) state_d   = ST_LOCKED;
                  else                         arb_point = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!cur_lock && cur_htrans == HT_IDLE) arb_point = 1'b1;
            end
            default: ;
         endcase
      end

      can_switch = bus.slv_HREADY & ((state_q == ST_IDLE) | arb_point);
      grant_load = can_switch & any_req;

      if (can_switch) begin
         beats_d     = '0;
         lock_pend_d = 1'b0;
         if (any_req) begin
            grant_d         = MASTERS'(1) << winner;
            idx_d           = winner;
            ptr_d[win_tier] = winner;
            gv_d            = 1'b1;
            state_d         = ST_OWNED;
         end else begin
            // Park on the current master.
            gv_d    = 1'b0;
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q     <= ST_IDLE;
         beats_q     <= '0;
         lock_pend_q <= 1'b0;
         grant_q     <= MASTERS'(1);
         idx_q       <= '0;
         gv_q        <= 1'b0;
         for (int t = 0; t < TIERS; t++) ptr_q[t] <= '0;
      end else begin
         state_q     <= state_d;
         beats_q     <= beats_d;
         lock_pend_q <= lock_pend_d;
         grant_q     <= grant_d;
         idx_q       <= idx_d;
         gv_q        <= gv_d;
         ptr_q       <= ptr_d;
      end
   end

   // Aging runs every cycle, independent of slv_HREADY. A parked grant
   // (grant_valid=0) is not ownership, so a parked master still ages.
   for (genvar gi = 0; gi < MASTERS; gi++) begin : g_age
      logic [7:0] age_q, age_d;
      logic       starved_q;

      always_comb begin
         age_d = age_q;
         if (!bus.mst_req[gi] || (grant_load && winner == IDXW'(gi))) begin
            age_d = '0;
         end else if (!(grant_q[gi] && gv_q) && age_q < AGE_MAX) begin
            age_d = age_q + 8'd1;
         end
      end

      always_ff @(posedge HCLK or posedge HRESET) begin
         if (HRESET) begin
            age_q     <= '0;
            starved_q <= 1'b0;
         end else begin
            age_q     <= age_d;
            starved_q <= (age_d == AGE_MAX);
         end
      end

      assign starved_vec[gi] = starved_q;
   end

   assign bus.granted_master     = grant_q;
   assign bus.granted_master_idx = idx_q;
   assign bus.grant_valid        = gv_q;
   assign bus.can_switch         = can_switch;
   assign bus.starved            = starved_vec;
endmodule

// File: tb/tb_peripheral_msi_arbiter_ahb3.sv
module tb_peripheral_msi_arbiter_ahb3;
   localparam int MASTERS = 5;
   localparam int SEL_IDX = 0;
   localparam int SEL_OH  = 1;
   localparam int SEL_GV  = 2;
   localparam int SEL_CS  = 3;
   localparam int SEL_STV = 4;

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   typedef struct {
      string tag;
      int    sel;
      int    val;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   exp_t now_q [$];
   exp_t nxt_q [$];

   // Burst stimulus for the INCR4 test: beats after the NONSEQ.
   logic [1:0] b_ht  [7] = '{HT_SEQ, HT_BUSY, HT_SEQ, HT_SEQ, HT_SEQ, HT_SEQ, HT_SEQ};
   logic       b_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   peripheral_msi_arbiter_ahb3_if #(.MASTERS(MASTERS)) bus ();

   peripheral_msi_arbiter_ahb3 #(.MASTERS(MASTERS), .AGE_LIMIT(15)) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, int got, int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int observe(int sel);
      case (sel)
         SEL_IDX: return int'(bus.granted_master_idx);
         SEL_OH:  return int'(bus.granted_master);
         SEL_GV:  return int'(bus.grant_valid);
         SEL_CS:  return int'(bus.can_switch);
         default: return int'(bus.starved);
      endcase
   endfunction

   task automatic push_now(string tag, int sel, int val);
      exp_t e;
      e.tag = tag; e.sel = sel; e.val = val;
      now_q.push_back(e);
   endtask

   task automatic push_nxt(string tag, int sel, int val);
      exp_t e;
      e.tag = tag; e.sel = sel; e.val = val;
      nxt_q.push_back(e);
   endtask

   task automatic push_cs(string tag, int v);
      push_now({tag, ".cs"}, SEL_CS, v);
   endtask

   task automatic push_grant(string tag, int idx, int gv);
      push_nxt({tag, ".idx"}, SEL_IDX, idx);
      push_nxt({tag, ".oh"},  SEL_OH,  1 << idx);
      push_nxt({tag, ".gv"},  SEL_GV,  gv);
   endtask

   task automatic push_stv(string tag, int v);
      push_nxt({tag, ".stv"}, SEL_STV, v);
   endtask

   task automatic drain_now();
      exp_t e;
      while (now_q.size() > 0) begin
         e = now_q.pop_front();
         chk(e.tag, observe(e.sel), e.val);
      end
   endtask

   task automatic drain_nxt();
      exp_t e;
      while (nxt_q.size() > 0) begin
         e = nxt_q.pop_front();
         chk(e.tag, observe(e.sel), e.val);
      end
   endtask

   // One bus cycle: combinational checks mid-cycle, registered checks after the edge.
   task automatic tick();
      @(negedge clk);
      drain_now();
      @(posedge clk);
      #1;
      drain_nxt();
      $display("cycle t=%0t idx=%0d gv=%0d cs=%0d starved=%b",
               $time, bus.granted_master_idx, bus.grant_valid, bus.can_switch, bus.starved);
   endtask

   task automatic drive(int m, bit req, int prio, logic [1:0] ht, logic [2:0] hb, bit lock);
      bus.mst_req[m]       = req;
      bus.mst_priority[m]  = 3'(prio);
      bus.mst_HTRANS[m]    = ht;
      bus.mst_HBURST[m]    = hb;
      bus.mst_HMASTLOCK[m] = lock;
   endtask

   task automatic idle_all();
      for (int m = 0; m < MASTERS; m++) drive(m, 1'b0, 0, HT_IDLE, 3'd0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur;
      int oth;
      int tmp;
      logic [1:0] ht;

      rst = 1'b1;
      bus.slv_HREADY = 1'b1;
      idle_all();
      repeat (2) @(posedge clk);
      #1;
      push_grant("rst", 0, 0);
      push_stv("rst", 0);
      drain_nxt();
      rst = 1'b0;

      // No requests: parked on master 0, arbitration point every cycle.
      for (int i = 0; i < 3; i++) begin
         push_cs("noreq", 1);
         push_grant("noreq", 0, 0);
         push_stv("noreq", 0);
         tick();
      end

      // Masters 1 and 3 at priority 2, single transfers: alternating grants.
      drive(1, 1'b1, 2, HT_NONSEQ, 3'd0, 1'b0);
      drive(3, 1'b1, 2, HT_NONSEQ, 3'd0, 1'b0);
      push_cs("rr.first", 1);
      push_grant("rr.first", 1, 1);
      tick();
      cur = 1;
      oth = 3;
      for (int i = 0; i < 4; i++) begin
         drive(cur, 1'b1, 2, HT_NONSEQ, 3'd0, 1'b0);
         drive(oth, 1'b1, 2, HT_NONSEQ, 3'd0, 1'b0);
         push_cs("rr.data", 0);
         push_grant("rr.data", cur, 1);
         tick();
         drive(cur, 1'b0, 2, HT_IDLE, 3'd0, 1'b0);
         push_cs("rr.sw", 1);
         push_grant("rr.sw", oth, 1);
         tick();
         tmp = cur; cur = oth; oth = tmp;
      end
      idle_all();
      push_cs("rr.end", 1);
      push_grant("rr.end", 1, 0);
      tick();

      // Master 2 INCR4 with BUSY and wait states; master 4 at priority 7 waits.
      drive(2, 1'b1, 3, HT_NONSEQ, 3'd3, 1'b0);
      push_cs("bst.arb", 1);
      push_grant("bst.arb", 2, 1);
      tick();
      drive(4, 1'b1, 7, HT_NONSEQ, 3'd0, 1'b0);
      push_cs("bst.nseq", 0);
      push_grant("bst.nseq", 2, 1);
      tick();
      for (int i = 0; i < 7; i++) begin
         drive(2, b_ht[i][1], 3, b_ht[i], 3'd3, 1'b0);
         bus.slv_HREADY = b_rdy[i];
         push_cs("bst.beat", (i == 6) ? 1 : 0);
         push_grant("bst.beat", (i == 6) ? 4 : 2, 1);
         tick();
      end
      drive(2, 1'b0, 3, HT_IDLE, 3'd0, 1'b0);
      push_cs("bst.m4", 0);
      push_grant("bst.m4", 4, 1);
      tick();
      idle_all();
      push_cs("bst.end", 1);
      push_grant("bst.end", 4, 0);
      tick();

      // Master 0 locked across two INCR8 bursts; master 1 at priority 7 waits.
      drive(1, 1'b0, 7, HT_IDLE, 3'd0, 1'b0);
      drive(0, 1'b1, 0, HT_NONSEQ, 3'd5, 1'b1);
      push_cs("lck.arb", 1);
      push_grant("lck.arb", 0, 1);
      tick();
      drive(1, 1'b1, 7, HT_NONSEQ, 3'd0, 1'b0);
      for (int k = 1; k <= 18; k++) begin
         if (k == 1 || k == 9) ht = HT_NONSEQ;
         else if (k <= 16)     ht = HT_SEQ;
         else if (k == 17)     ht = HT_IDLE;
         else                  ht = HT_NONSEQ;
         drive(0, ht[1], 0, ht, 3'd5, k <= 17);
         push_cs("lck.hold", 0);
         push_grant("lck.hold", 0, 1);
         if (k == 17) push_stv("lck.age", 2);
         tick();
      end
      drive(0, 1'b0, 0, HT_IDLE, 3'd0, 1'b0);
      push_cs("lck.rel", 1);
      push_grant("lck.rel", 1, 1);
      push_stv("lck.rel", 0);
      tick();
      push_cs("lck.m1", 0);
      push_grant("lck.m1", 1, 1);
      tick();
      idle_all();
      push_cs("lck.end", 1);
      push_grant("lck.end", 1, 0);
      tick();

      // Starvation: master 4 at priority 7 hogs, master 0 at priority 0 ages.
      drive(4, 1'b1, 7, HT_NONSEQ, 3'd0, 1'b0);
      drive(0, 1'b1, 0, HT_NONSEQ, 3'd0, 1'b0);
      push_cs("stv.arb", 1);
      push_grant("stv.arb", 4, 1);
      tick();
      for (int k = 1; k <= 16; k++) begin
         drive(4, 1'b1, 7, (k % 2 == 1) ? HT_NONSEQ : HT_IDLE, 3'd0, 1'b0);
         push_cs("stv.cyc", (k % 2 == 0) ? 1 : 0);
         push_grant("stv.cyc", (k < 16) ? 4 : 0, 1);
         push_stv("stv.cyc", (k >= 14 && k < 16) ? 1 : 0);
         tick();
      end

      // Reset asserted mid-burst.
      drive(4, 1'b0, 7, HT_IDLE, 3'd0, 1'b0);
      drive(0, 1'b1, 0, HT_NONSEQ, 3'd7, 1'b0);
      push_cs("rb.nseq", 0);
      push_grant("rb.nseq", 0, 1);
      tick();
      drive(0, 1'b1, 0, HT_SEQ, 3'd7, 1'b0);
      push_cs("rb.seq", 0);
      push_grant("rb.seq", 0, 1);
      tick();
      #2;
      rst = 1'b1;
      idle_all();
      #1;
      push_cs("rb.async", 1);
      push_grant("rb.async", 0, 0);
      push_stv("rb.async", 0);
      drain_now();
      drain_nxt();
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      // Tier-2 pointer was left at master 1 before reset; after reset it is 0.
      drive(1, 1'b1, 2, HT_NONSEQ, 3'd0, 1'b0);
      drive(3, 1'b1, 2, HT_NONSEQ, 3'd0, 1'b0);
      push_cs("rb.post", 1);
      push_grant("rb.post", 1, 1);
      tick();
      drive(3, 1'b0, 2, HT_IDLE, 3'd0, 1'b0);
      push_cs("rb.own", 0);
      push_grant("rb.own", 1, 1);
      tick();
      idle_all();
      push_cs("rb.end", 1);
      push_grant("rb.end", 1, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
